// File: rtl/toggle_rate_monitor.sv
// Counts transitions of an upstream toggle flop over a WIN_LEN-cycle window and reports the count, saturating with a sticky overflow flag.
// Result appears the cycle after the window ends; it is held in REPORT until cnt_valid & cnt_ready, and no events are counted meanwhile.
module toggle_rate_monitor #(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tog_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             overflow,
    output logic             busy
);

    localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WIN_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_REPORT
    } state_t;

    state_t             r_state;
    logic               r_tog_q;
    logic [WIN_W-1:0]   r_win;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_valid;
    logic               w_event;

    assign w_event   = tog_in ^ r_tog_q;
    assign cnt_out   = r_cnt;
    assign overflow  = r_ovf;
    assign cnt_valid = r_valid;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tog_q <= 1'b0;
            r_win   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_tog_q <= tog_in;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_COUNT;
                        r_win   <= WIN_LOAD;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_COUNT: begin
                    // Counter holds at all-ones; any event beyond that marks the window as saturated.
                    if (w_event) begin
                        if (&r_cnt) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    if (r_win == '0) begin
                        r_state <= S_REPORT;
                        r_valid <= 1'b1;
                    end else begin
                        r_win <= r_win - WIN_W'(1);
                    end
                end
                S_REPORT: begin
                    if (cnt_ready) begin
                        r_valid <= 1'b0;
                        if (en) begin
                            r_state <= S_COUNT;
                            r_win   <= WIN_LOAD;
                            r_cnt   <= '0;
                            r_ovf   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_rate_monitor.sv
// Directed bench for toggle_rate_monitor: default instance plus a CNT_W=3 instance for saturation.
// Expected results are queued at stimulus time and popped by per-instance monitors on each handshake.
module tb_toggle_rate_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tog = 1'b0;
    logic       phase = 1'b0;
    int         tog_mode = 0;
    int         cyc = 0;

    logic       en = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] cnt_out;
    logic       cnt_valid, overflow, busy;

    logic       s_en = 1'b0;
    logic       s_ready = 1'b1;
    logic [2:0] s_cnt_out;
    logic       s_cnt_valid, s_overflow, s_busy;

    typedef struct {int cnt; int ovf;} exp_t;
    exp_t q_d[$];
    exp_t q_s[$];
    exp_t e_d, e_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    toggle_rate_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tog_in(tog),
        .cnt_out(cnt_out), .cnt_valid(cnt_valid), .cnt_ready(ready),
        .overflow(overflow), .busy(busy)
    );

    toggle_rate_monitor #(.CNT_W(3), .WIN_LEN(16)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(s_en), .tog_in(tog),
        .cnt_out(s_cnt_out), .cnt_valid(s_cnt_valid), .cnt_ready(s_ready),
        .overflow(s_overflow), .busy(s_busy)
    );

    // Upstream enable-gated toggle flop: mode 0 idle, 1 always enabled, 2 enabled every other cycle.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        phase <= ~phase;
        case (tog_mode)
            1: tog <= ~tog;
            2: if (phase) tog <= ~tog;
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cnt_valid && ready) begin
            if (q_d.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dflt_unexpected_result: got cnt %0d, expected no result", cnt_out);
            end else begin
                e_d = q_d.pop_front();
                chk("dflt_cnt", 32'(cnt_out), e_d.cnt);
                chk("dflt_ovf", 32'(overflow), e_d.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_cnt_valid && s_ready) begin
            if (q_s.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sat_unexpected_result: got cnt %0d, expected no result", s_cnt_out);
            end else begin
                e_s = q_s.pop_front();
                chk("sat_cnt", 32'(s_cnt_out), e_s.cnt);
                chk("sat_ovf", 32'(s_overflow), e_s.ovf);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input bit sat, output int busy_n);
        bit seen;
        seen   = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sat ? s_cnt_valid : cnt_valid) begin
                seen = 1'b1;
                break;
            end
            if (sat ? s_busy : busy) busy_n++;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid_timeout: got no cnt_valid in 200 cycles, expected one (sat=%0d)", sat);
        end
    endtask

    task automatic run_window(input int exp_cnt, input int mode);
        int nb;
        tog_mode = mode;
        ready    = 1'b1;
        q_d.push_back('{exp_cnt, 0});
        en = 1'b1;
        step();
        en = 1'b0;
        wait_valid(1'b0, nb);
        chk("win_busy_cycles", nb, 16);
        step();
        chk("win_back_idle", {30'd0, busy, cnt_valid}, 0);
    endtask

    initial begin
        int nb;
        int t[4];

        // Reset held with the toggle source running.
        tog_mode = 1;
        repeat (5) begin
            step();
            chk("reset_outputs", {20'd0, cnt_out, cnt_valid, overflow, busy}, 0);
            chk("reset_sat_outputs", {26'd0, s_cnt_out, s_cnt_valid, s_overflow, s_busy}, 0);
        end
        rst_n = 1'b1;
        repeat (20) begin
            step();
            chk("idle_hold", {30'd0, busy, cnt_valid}, 0);
        end

        // Full-rate window with consumer stalled for 5 cycles.
        ready = 1'b0;
        q_d.push_back('{16, 0});
        en = 1'b1;
        step();
        en = 1'b0;
        wait_valid(1'b0, nb);
        chk("full_busy_cycles", nb, 16);
        step();
        repeat (5) begin
            chk("stall_cnt", 32'(cnt_out), 16);
            chk("stall_valid", 32'(cnt_valid), 1);
            chk("stall_ovf", 32'(overflow), 0);
            step();
        end
        ready = 1'b1;
        step();
        chk("full_back_idle", {30'd0, busy, cnt_valid}, 0);

        run_window(8, 2);
        run_window(0, 0);

        // Saturation on the 3-bit instance, then a quiet window clears it.
        tog_mode = 1;
        q_s.push_back('{7, 1});
        s_en = 1'b1;
        step();
        s_en = 1'b0;
        wait_valid(1'b1, nb);
        step();
        chk("sat_back_idle", 32'(s_busy), 0);
        tog_mode = 0;
        q_s.push_back('{0, 0});
        s_en = 1'b1;
        step();
        s_en = 1'b0;
        wait_valid(1'b1, nb);
        step();
        chk("sat2_back_idle", 32'(s_busy), 0);

        // Back-to-back windows; en dropped during the fourth.
        tog_mode = 1;
        ready = 1'b1;
        repeat (4) q_d.push_back('{16, 0});
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(1'b0, nb);
            t[i] = cyc;
            step();
            if (i == 2) en = 1'b0;
            @(negedge clk);
            chk("b2b_valid_one_cycle", 32'(cnt_valid), 0);
        end
        chk("b2b_period_0", t[1] - t[0], 17);
        chk("b2b_period_1", t[2] - t[1], 17);
        chk("b2b_period_2", t[3] - t[2], 17);
        step();
        chk("b2b_back_idle", 32'(busy), 0);

        // Reset during COUNT cycle 7, then a clean window.
        tog_mode = 1;
        en = 1'b1;
        step();
        en = 1'b0;
        repeat (6) step();
        chk("midrst_was_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {20'd0, cnt_out, cnt_valid, overflow, busy}, 0);
        en = 1'b1;
        step();
        step();
        q_d.push_back('{16, 0});
        rst_n = 1'b1;
        step();
        en = 1'b0;
        wait_valid(1'b0, nb);
        chk("midrst_busy_cycles", nb, 16);
        step();
        chk("midrst_back_idle", {30'd0, busy, cnt_valid}, 0);

        repeat (3) step();
        chk("queues_drained", q_d.size() + q_s.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
